// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_display_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic       blank;
        logic [3:0] data;
    } digit_entry_t;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    localparam digit_entry_t ENTRY_RESET = '{blank: 1'b1, data: 4'h0};

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_display_scanner_decoder.sv
// Active-low 4-bit hex to 7-segment decoder; o_seg[0] is segment a, o_seg[6] is segment g.
module hex_display_scanner_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [0:6] o_seg
);

    // Glyph lookup, lowercase b and d so they differ from 8 and 0.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0:    o_seg = 7'b0000001;
            4'h1:    o_seg = 7'b1001111;
            4'h2:    o_seg = 7'b0010010;
            4'h3:    o_seg = 7'b0000110;
            4'h4:    o_seg = 7'b1001100;
            4'h5:    o_seg = 7'b0100100;
            4'h6:    o_seg = 7'b0100000;
            4'h7:    o_seg = 7'b0001111;
            4'h8:    o_seg = 7'b0000000;
            4'h9:    o_seg = 7'b0000100;
            4'hA:    o_seg = 7'b0001000;
            4'hB:    o_seg = 7'b1100000;
            4'hC:    o_seg = 7'b0110001;
            4'hD:    o_seg = 7'b1000010;
            4'hE:    o_seg = 7'b0110000;
            4'hF:    o_seg = 7'b0111000;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Scans NUM_DIGITS common-anode digits through one shared decoder, with a
// double-buffered digit table that is swapped only at frame boundaries.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int GAP_TICKS       = 500
) (
    input  logic                          Clk,
    input  logic                          ResetN,
    input  logic                          Enable,
    input  logic                          WrValid,
    output logic                          WrReady,
    input  logic [$clog2(NUM_DIGITS)-1:0] WrIdx,
    input  logic [3:0]                    WrData,
    input  logic                          WrBlank,
    input  logic                          Commit,
    output logic                          CommitDone,
    output logic                          FrameStart,
    output logic [0:6]                    Seg,
    output logic [NUM_DIGITS-1:0]         DigitEn
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(max_int(TICKS_PER_DIGIT, GAP_TICKS) + 1);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam bit               HAS_GAP    = (GAP_TICKS > 0);

    scan_state_t           r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    digit_entry_t          r_shadow [NUM_DIGITS];
    digit_entry_t          r_active [NUM_DIGITS];
    logic                  r_pending;
    logic [0:6]            r_seg;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_commit_done;
    logic                  r_frame_start;

    scan_state_t           w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_frame_start;
    logic                  w_copy;
    logic                  w_wr_accept;
    digit_entry_t          w_cur;
    logic [0:6]            w_dec_seg;
    logic [0:6]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_en_nxt;

    hex_display_scanner_decoder u_decoder (
        .i_hex (w_cur.data),
        .o_seg (w_dec_seg)
    );

    // Digit index following the current one, wrapping at the last digit.
    always_comb begin
        w_idx_inc = r_idx + IDX_W'(1);
        if (r_idx == IDX_LAST) begin
            w_idx_inc = '0;
        end else begin
            w_idx_inc = r_idx + IDX_W'(1);
        end
    end

    // Scan sequencing; w_frame_start marks the edge that enters DRIVE of digit 0.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_frame_start = 1'b0;
        if (!Enable) begin
            w_state_nxt = OFF;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                OFF: begin
                    w_state_nxt   = DRIVE;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_frame_start = 1'b1;
                end
                DRIVE: begin
                    if (r_cnt == DRIVE_LAST) begin
                        w_cnt_nxt = '0;
                        if (HAS_GAP) begin
                            w_state_nxt = GAP;
                        end else begin
                            w_state_nxt   = DRIVE;
                            w_idx_nxt     = w_idx_inc;
                            w_frame_start = (w_idx_inc == '0);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_nxt   = DRIVE;
                        w_idx_nxt     = w_idx_inc;
                        w_cnt_nxt     = '0;
                        w_frame_start = (w_idx_inc == '0);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = OFF;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Table swap and write acceptance; a swap and a write can never share an edge.
    always_comb begin
        w_copy      = r_pending && ((r_state == OFF) || w_frame_start);
        w_wr_accept = WrValid && !r_pending;
    end

    // Select the active entry for the digit being scanned and form the next bus values.
    always_comb begin
        w_cur = r_active[0];
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_cur = r_active[d];
            end else begin
                w_cur = w_cur;
            end
        end
        if ((r_state == DRIVE) && !w_cur.blank) begin
            w_seg_nxt = w_dec_seg;
            w_en_nxt  = ~(NUM_DIGITS'(1) << r_idx);
        end else begin
            w_seg_nxt = SEG_BLANK;
            w_en_nxt  = '1;
        end
    end

    // State, tables, handshake and registered display outputs.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state       <= OFF;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_seg         <= SEG_BLANK;
            r_digit_en    <= '1;
            r_commit_done <= 1'b0;
            r_frame_start <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                r_shadow[d] <= ENTRY_RESET;
                r_active[d] <= ENTRY_RESET;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_seg         <= w_seg_nxt;
            r_digit_en    <= w_en_nxt;
            r_commit_done <= w_copy;
            r_frame_start <= w_frame_start;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (w_copy) begin
                    r_active[d] <= r_shadow[d];
                end
                if (w_wr_accept && (WrIdx == IDX_W'(d))) begin
                    r_shadow[d] <= '{blank: WrBlank, data: WrData};
                end
            end
            if (w_copy) begin
                r_pending <= 1'b0;
            end else if (Commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign WrReady    = !r_pending;
    assign CommitDone = r_commit_done;
    assign FrameStart = r_frame_start;
    assign Seg        = r_seg;
    assign DigitEn    = r_digit_en;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: directed scenarios plus random
// traffic compared cycle by cycle against a frame-position reference model.
module tb_hex_display_scanner;

    localparam int ND    = 4;
    localparam int TPD   = 4;
    localparam int GT    = 1;
    localparam int SLOT  = TPD + GT;
    localparam int FRAME = SLOT * ND;

    logic       Clk = 1'b0;
    logic       ResetN, Enable, WrValid, WrBlank, Commit;
    logic [1:0] WrIdx;
    logic [3:0] WrData;
    logic       WrReady, CommitDone, FrameStart;
    logic [0:6] Seg;
    logic [3:0] DigitEn;

    hex_display_scanner #(
        .NUM_DIGITS      (ND),
        .TICKS_PER_DIGIT (TPD),
        .GAP_TICKS       (GT)
    ) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Enable     (Enable),
        .WrValid    (WrValid),
        .WrReady    (WrReady),
        .WrIdx      (WrIdx),
        .WrData     (WrData),
        .WrBlank    (WrBlank),
        .Commit     (Commit),
        .CommitDone (CommitDone),
        .FrameStart (FrameStart),
        .Seg        (Seg),
        .DigitEn    (DigitEn)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Segment images abcdefg, active-low.
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: scanning is a position within a 20-cycle frame.
    bit         m_on;
    int         m_pos;
    bit         m_pend;
    bit         m_sh_b  [ND];
    logic [3:0] m_sh_d  [ND];
    bit         m_act_b [ND];
    logic [3:0] m_act_d [ND];
    logic [6:0] m_seg;
    logic [3:0] m_en;
    bit         m_fs, m_cd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [6:0] nseg;
        logic [3:0] nen;
        bit was_off, fs, copy;
        int d;
        if (!ResetN) begin
            m_on = 0; m_pos = 0; m_pend = 0;
            for (int i = 0; i < ND; i++) begin
                m_sh_b[i] = 1; m_sh_d[i] = 4'h0; m_act_b[i] = 1; m_act_d[i] = 4'h0;
            end
            m_seg = 7'h7F; m_en = 4'hF; m_fs = 0; m_cd = 0;
        end else begin
            nseg = 7'h7F;
            nen  = 4'hF;
            d    = m_pos / SLOT;
            if (m_on && (m_pos % SLOT) < TPD && !m_act_b[d]) begin
                nseg = seg_tab[m_act_d[d]];
                nen  = 4'hF & ~(4'b0001 << d);
            end
            was_off = !m_on;
            fs = 0;
            if (!Enable) begin
                m_on = 0;
            end else if (!m_on) begin
                m_on = 1; m_pos = 0; fs = 1;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
                fs = (m_pos == 0);
            end
            copy = m_pend && (was_off || fs);
            if (copy) begin
                for (int i = 0; i < ND; i++) begin
                    m_act_b[i] = m_sh_b[i]; m_act_d[i] = m_sh_d[i];
                end
            end
            if (WrValid && !m_pend) begin
                m_sh_b[WrIdx] = WrBlank; m_sh_d[WrIdx] = WrData;
            end
            if (copy) m_pend = 0;
            else if (Commit) m_pend = 1;
            m_seg = nseg; m_en = nen; m_fs = fs; m_cd = copy;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check_eq("seg",         32'(Seg),        32'(m_seg));
        check_eq("digit_en",    32'(DigitEn),    32'(m_en));
        check_eq("frame_start", 32'(FrameStart), 32'(m_fs));
        check_eq("commit_done", 32'(CommitDone), 32'(m_cd));
        check_eq("wr_ready",    32'(WrReady),    32'(!m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int idx, input int val, input bit blank);
        WrValid = 1'b1; WrIdx = 2'(idx); WrData = 4'(val); WrBlank = blank;
        tick();
        WrValid = 1'b0;
    endtask

    task automatic commit_pulse();
        Commit = 1'b1;
        tick();
        Commit = 1'b0;
    endtask

    initial begin
        int cd_count;
        bit seen;
        ResetN = 1'b0; Enable = 1'b0; WrValid = 1'b0; WrBlank = 1'b0;
        Commit = 1'b0; WrIdx = 2'd0; WrData = 4'h0;
        run(2);
        ResetN = 1'b1;

        // Reset asserted for two cycles while scanning.
        wr(1, 5, 0);
        commit_pulse();
        Enable = 1'b1;
        run(3);
        ResetN = 1'b0;
        run(2);
        check_eq("t1_seg",  32'(Seg),        32'h7F);
        check_eq("t1_en",   32'(DigitEn),    32'hF);
        check_eq("t1_rdy",  32'(WrReady),    32'h1);
        check_eq("t1_fs",   32'(FrameStart), 32'h0);
        check_eq("t1_cd",   32'(CommitDone), 32'h0);
        ResetN = 1'b1; Enable = 1'b0;
        tick();

        // Load 1,2,3,A and start scanning.
        wr(0, 1, 0); wr(1, 2, 0); wr(2, 3, 0); wr(3, 10, 0);
        commit_pulse();
        tick();
        Enable = 1'b1;
        tick();
        check_eq("t2_fs0", 32'(FrameStart), 32'h1);
        for (int c = 1; c <= FRAME; c++) begin
            tick();
            if (c <= 4) begin
                check_eq("t2_en_d0",  32'(DigitEn), 32'hE);
                check_eq("t2_seg_d0", 32'(Seg),     32'h4F);
            end else if (c == 5) begin
                check_eq("t2_en_gap", 32'(DigitEn), 32'hF);
            end else if (c <= 9) begin
                check_eq("t2_en_d1",  32'(DigitEn), 32'hD);
                check_eq("t2_seg_d1", 32'(Seg),     32'h12);
            end else if (c == FRAME) begin
                check_eq("t2_fs20", 32'(FrameStart), 32'h1);
            end
        end

        // Mid-frame write of 8 to digit 0, swapped only at the boundary.
        run(7);
        wr(0, 8, 0);
        commit_pulse();
        seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            tick();
            if (CommitDone) begin
                seen = 1;
                check_eq("t3_fs_with_cd", 32'(FrameStart), 32'h1);
            end else begin
                check_eq("t3_rdy_low", 32'(WrReady), 32'h0);
                if (DigitEn == 4'hE) check_eq("t3_old_d0", 32'(Seg), 32'h4F);
            end
        end
        check_eq("t3_commit_seen", 32'(seen), 32'h1);
        tick();
        check_eq("t3_new_d0_en",  32'(DigitEn), 32'hE);
        check_eq("t3_new_d0_seg", 32'(Seg),     32'h00);

        // Blank digit 2.
        wr(2, 3, 1);
        commit_pulse();
        run(2 * FRAME);

        // Double commit and write while not ready.
        run(3);
        commit_pulse();
        wr(1, 5, 0);
        commit_pulse();
        cd_count = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            if (CommitDone) cd_count++;
        end
        check_eq("t5_cd_count", 32'(cd_count), 32'h1);
        run(FRAME);

        // Enable drop with a commit pending.
        run(2);
        wr(3, 7, 0);
        commit_pulse();
        Enable = 1'b0;
        cd_count = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (CommitDone) cd_count++;
        end
        check_eq("t6_cd_in_off", 32'(cd_count), 32'h1);
        check_eq("t6_seg_off",   32'(Seg),      32'h7F);
        check_eq("t6_en_off",    32'(DigitEn),  32'hF);
        Enable = 1'b1;
        tick();
        check_eq("t6_fs_restart", 32'(FrameStart), 32'h1);
        run(FRAME);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ResetN  = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 99) == 0) Enable = ~Enable;
            WrValid = ($urandom_range(0, 3) == 0);
            WrIdx   = 2'($urandom_range(0, 3));
            WrData  = 4'($urandom_range(0, 15));
            WrBlank = ($urandom_range(0, 7) == 0);
            Commit  = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
